// File: rtl/kernel_channel_psum_collector.sv
// Collects per-kernel psums from the PE array, accumulates them across channel-group
// passes in a per-pixel buffer and streams final sums out through a small skid FIFO.
module kernel_channel_psum_collector #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int MAX_PIXEL  = 256,
    parameter int PIX_WIDTH  = 9,
    parameter int PASS_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [PIX_WIDTH-1:0]             i_num_pixel,
    input  logic [PASS_WIDTH-1:0]            i_num_pass,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0]  i_psum,
    input  logic [NUM_KERNEL-1:0]            i_psum_val,
    output logic                             o_wr_val,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0]  o_wr_data,
    input  logic                             i_wr_ready,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [REG_WIDTH-1:0]             err_psum
);

    localparam int WORD_W  = BIT_WIDTH * NUM_KERNEL;
    localparam int BUF_AW  = (MAX_PIXEL > 1) ? $clog2(MAX_PIXEL) : 1;
    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = ADDR_WIDTH + WORD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [PIX_WIDTH-1:0]    num_pixel;
    logic [PIX_WIDTH-1:0]    pix_cnt;
    logic [PASS_WIDTH-1:0]   num_pass;
    logic [PASS_WIDTH-1:0]   pass_cnt;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [4:0]              err_bits;

    logic [WORD_W-1:0]       psum_buf [MAX_PIXEL];
    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]      fifo_wr_ptr;
    logic [FIFO_AW-1:0]      fifo_rd_ptr;
    logic [FIFO_AW:0]        fifo_cnt;

    logic                    psum_any;
    logic                    psum_beat;
    logic                    psum_partial;
    logic                    accum_beat;
    logic                    first_pass;
    logic                    last_pass;
    logic                    last_pixel;
    logic                    pix_over;
    logic [PIX_WIDTH-1:0]    start_pixel;
    logic [WORD_W-1:0]       buf_rd;
    logic [WORD_W-1:0]       sum_word;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic                    fifo_push_req;
    logic                    fifo_push;
    logic                    drain_empty;
    logic [ENTRY_W-1:0]      fifo_head;

    // Stream classification: only an all-ones valid vector is a usable beat.
    assign psum_any     = (i_psum_val != '0);
    assign psum_beat    = (i_psum_val == '1);
    assign psum_partial = psum_any && !psum_beat;
    assign accum_beat   = (state == S_ACCUM) && psum_beat;

    assign first_pass   = (pass_cnt == '0);
    assign last_pass    = (pass_cnt == num_pass - PASS_WIDTH'(1));
    assign last_pixel   = (pix_cnt == num_pixel - PIX_WIDTH'(1));

    assign pix_over     = (i_num_pixel > PIX_WIDTH'(MAX_PIXEL));
    assign start_pixel  = pix_over ? PIX_WIDTH'(MAX_PIXEL) : i_num_pixel;

    assign buf_rd       = psum_buf[pix_cnt[BUF_AW-1:0]];
    assign wr_addr      = base_addr + ADDR_WIDTH'(pix_cnt);

    // Each lane wraps modulo 2^BIT_WIDTH; the first pass overwrites stale buffer data.
    always_comb begin
        sum_word = '0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if (first_pass) begin
                sum_word[k*BIT_WIDTH +: BIT_WIDTH] = i_psum[k*BIT_WIDTH +: BIT_WIDTH];
            end else begin
                sum_word[k*BIT_WIDTH +: BIT_WIDTH] = buf_rd[k*BIT_WIDTH +: BIT_WIDTH]
                                                   + i_psum[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign fifo_full     = (fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_pop      = o_wr_val && i_wr_ready;
    assign fifo_push_req = accum_beat && last_pass;
    assign fifo_push     = fifo_push_req && (!fifo_full || fifo_pop);
    assign drain_empty   = (fifo_cnt == '0) || ((fifo_cnt == (FIFO_AW+1)'(1)) && fifo_pop);

    assign fifo_head     = fifo_mem[fifo_rd_ptr];
    assign o_wr_val      = (fifo_cnt != '0);
    assign o_wr_addr     = o_wr_val ? fifo_head[ENTRY_W-1:WORD_W] : '0;
    assign o_wr_data     = o_wr_val ? fifo_head[WORD_W-1:0] : '0;

    assign err_psum      = {{(REG_WIDTH-5){1'b0}}, err_bits};

    always_ff @(posedge clk) begin
        if (accum_beat && !last_pass) begin
            psum_buf[pix_cnt[BUF_AW-1:0]] <= sum_word;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= {wr_addr, sum_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + FIFO_AW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + FIFO_AW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            num_pixel <= '0;
            num_pass  <= '0;
            base_addr <= '0;
            pix_cnt   <= '0;
            pass_cnt  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            err_bits  <= '0;
        end else begin
            o_done <= 1'b0;

            if (psum_partial && state == S_ACCUM) begin
                err_bits[0] <= 1'b1;
            end
            if (fifo_push_req && fifo_full && !fifo_pop) begin
                err_bits[1] <= 1'b1;
            end
            if (i_start && state != S_IDLE) begin
                err_bits[3] <= 1'b1;
            end
            if (psum_any && (state == S_IDLE || state == S_DRAIN)) begin
                err_bits[4] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_pixel <= start_pixel;
                        num_pass  <= i_num_pass;
                        base_addr <= i_base_addr;
                        pix_cnt   <= '0;
                        pass_cnt  <= '0;
                        o_busy    <= 1'b1;
                        if (pix_over) begin
                            err_bits[2] <= 1'b1;
                        end
                        // An empty job passes through DRAIN with an empty FIFO, so it
                        // finishes with the same start-to-done latency as a real drain.
                        if (start_pixel == '0 || i_num_pass == '0) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (psum_beat) begin
                        if (last_pixel) begin
                            pix_cnt  <= '0;
                            pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                            if (last_pass) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + PIX_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_empty) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_channel_psum_collector.sv
// Randomized bench for kernel_channel_psum_collector: a pass-level lane-sum model feeds
// an expected write queue that is compared against every accepted write.
module tb_kernel_channel_psum_collector;

    localparam int BW   = 8;
    localparam int NK   = 4;
    localparam int MAXP = 256;
    localparam int PW   = 9;
    localparam int PSW  = 8;
    localparam int AW   = 16;
    localparam int FD   = 4;
    localparam int RW   = 32;
    localparam int DW   = BW * NK;

    logic           clk;
    logic           rst;
    logic           i_start;
    logic [PW-1:0]  i_num_pixel;
    logic [PSW-1:0] i_num_pass;
    logic [AW-1:0]  i_base_addr;
    logic [DW-1:0]  i_psum;
    logic [NK-1:0]  i_psum_val;
    logic           o_wr_val;
    logic [AW-1:0]  o_wr_addr;
    logic [DW-1:0]  o_wr_data;
    logic           i_wr_ready;
    logic           o_busy;
    logic           o_done;
    logic [RW-1:0]  err_psum;

    kernel_channel_psum_collector dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_num_pixel (i_num_pixel),
        .i_num_pass  (i_num_pass),
        .i_base_addr (i_base_addr),
        .i_psum      (i_psum),
        .i_psum_val  (i_psum_val),
        .o_wr_val    (o_wr_val),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_ready  (i_wr_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .err_psum    (err_psum)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard
    logic [AW+DW-1:0] exp_q[$];
    logic [RW-1:0]    exp_err = '0;
    logic [DW-1:0]    job_data [0:3][0:MAXP-1];
    int seen_wr     = 0;
    int done_cnt    = 0;
    int last_wr_cyc = 0;
    int ready_mode  = 0;

    always @(negedge clk) begin
        if (!rst && o_wr_val && i_wr_ready) begin
            seen_wr++;
            last_wr_cyc = cyc;
            check("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("wr_addr_data", {o_wr_addr, o_wr_data}, exp_q.pop_front());
        end
        if (o_done) done_cnt++;
    end

    initial begin
        i_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_wr_ready = 1'b1;
                1:       i_wr_ready = ($urandom_range(0, 3) != 0);
                default: i_wr_ready = 1'b0;
            endcase
        end
    end

    // Reference model: final word per pixel is the lane-wise sum over all passes mod 2^BW.
    task automatic model_job(input int npix, input int npass, input logic [AW-1:0] base);
        int eff;
        int lane;
        logic [DW-1:0] word;
        eff = (npix > MAXP) ? MAXP : npix;
        if (npass == 0) return;
        for (int p = 0; p < eff; p++) begin
            word = '0;
            for (int k = 0; k < NK; k++) begin
                lane = 0;
                for (int ps = 0; ps < npass; ps++) lane += int'(job_data[ps][p][k*BW +: BW]);
                word[k*BW +: BW] = BW'(lane % (1 << BW));
            end
            exp_q.push_back({base + AW'(p), word});
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int npass, input int npix);
        for (int ps = 0; ps < npass; ps++)
            for (int p = 0; p < npix; p++) job_data[ps][p] = DW'($urandom);
    endtask

    task automatic wait_done(input int start_cyc, input bit has_writes);
        bit got;
        int done_at;
        got = 0;
        done_at = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1;
                done_at = cyc;
                check("busy_at_done", o_busy, 1);
            end
        end
        check("done_seen", got, 1);
        if (got) begin
            if (has_writes) check("done_after_last_wr", done_at - last_wr_cyc, 1);
            else check("done_latency_empty", done_at - start_cyc, 2);
            check("wr_queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("idle_after_done", {o_done, o_busy}, 0);
            check("done_count", done_cnt, 1);
        end
    endtask

    task automatic run_job(input int npix, input int npass, input logic [AW-1:0] base,
                           input bit partials, input bit poke);
        int eff, start_cyc, last_beat_cyc, sent, seen0, wait_n;
        eff = (npix > MAXP) ? MAXP : npix;
        last_beat_cyc = 0;
        if (npix > MAXP) exp_err[2] = 1'b1;
        model_job(npix, npass, base);
        done_cnt = 0;
        step();
        i_start = 1'b1;
        i_num_pixel = PW'(npix);
        i_num_pass = PSW'(npass);
        i_base_addr = base;
        start_cyc = cyc;
        step();
        i_start = 1'b0;
        sent = 0;
        seen0 = seen_wr;
        if (poke) begin
            i_start = 1'b1;
            i_num_pixel = PW'($urandom_range(1, 50));
            i_num_pass = PSW'($urandom_range(1, 9));
            i_base_addr = AW'($urandom);
            exp_err[3] = 1'b1;
            step();
            i_start = 1'b0;
        end
        for (int ps = 0; ps < npass; ps++) begin
            for (int p = 0; p < eff; p++) begin
                repeat ($urandom_range(0, 2)) step();
                if (partials && $urandom_range(0, 4) == 0) begin
                    i_psum = DW'($urandom);
                    i_psum_val = NK'($urandom_range(1, (1 << NK) - 2));
                    exp_err[0] = 1'b1;
                    step();
                    i_psum_val = '0;
                end
                if (ps == npass - 1) begin
                    wait_n = 0;
                    while ((sent - (seen_wr - seen0)) >= FD && wait_n < 1000) begin
                        step();
                        wait_n++;
                    end
                end
                i_psum = job_data[ps][p];
                i_psum_val = '1;
                last_beat_cyc = cyc;
                step();
                i_psum_val = '0;
                if (ps == npass - 1) sent++;
            end
        end
        wait_done(start_cyc, (eff > 0) && (npass > 0));
        if (ready_mode == 0 && eff > 0 && npass > 0)
            check("last_wr_one_cycle_after_beat", last_wr_cyc - last_beat_cyc, 1);
        check("wr_count", seen_wr - seen0, (npass > 0) ? eff : 0);
        check("err_after_job", err_psum, exp_err);
    endtask

    initial begin
        int start_cyc, seen0;
        rst = 1'b1;
        i_start = 1'b0;
        i_num_pixel = '0;
        i_num_pass = '0;
        i_base_addr = '0;
        i_psum = '0;
        i_psum_val = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_val", o_wr_val, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", err_psum, 0);
        step();
        rst = 1'b0;

        // Single pass, 3 pixels
        job_data[0][0] = 32'h04030201;
        job_data[0][1] = 32'h08070605;
        job_data[0][2] = 32'h0C0B0A09;
        run_job(3, 1, 16'h0100, 0, 0);

        // Three passes of ones, then a lane-0 wrap over two passes
        for (int ps = 0; ps < 3; ps++) for (int p = 0; p < 2; p++) job_data[ps][p] = 32'h01010101;
        run_job(2, 3, 16'h0040, 0, 0);
        job_data[0][0] = 32'h000000FF;
        job_data[1][0] = 32'h00000002;
        run_job(1, 2, 16'h0080, 0, 0);

        // Address wrap at the top of the address space
        fill_random(2, 4);
        run_job(4, 2, 16'hFFFE, 0, 0);

        // Backpressure: six beats into a four-deep FIFO with the port stalled
        ready_mode = 2;
        i_wr_ready = 1'b0;
        fill_random(1, 6);
        for (int p = 0; p < 4; p++) exp_q.push_back({AW'(16'h0200 + p), job_data[0][p]});
        exp_err[1] = 1'b1;
        done_cnt = 0;
        seen0 = seen_wr;
        step();
        i_start = 1'b1;
        i_num_pixel = PW'(6);
        i_num_pass = PSW'(1);
        i_base_addr = 16'h0200;
        start_cyc = cyc;
        step();
        i_start = 1'b0;
        for (int p = 0; p < 6; p++) begin
            i_psum = job_data[0][p];
            i_psum_val = '1;
            step();
        end
        i_psum_val = '0;
        repeat (3) step();
        @(negedge clk);
        check("bp_wr_val_held", o_wr_val, 1);
        check("bp_busy", o_busy, 1);
        check("bp_overflow_err", err_psum, exp_err);
        ready_mode = 0;
        wait_done(start_cyc, 1);
        check("bp_wr_count", seen_wr - seen0, 4);

        // Valid in IDLE, then start during ACCUM with partial valids
        step();
        i_psum_val = 4'b0100;
        exp_err[4] = 1'b1;
        step();
        i_psum_val = '0;
        @(negedge clk);
        check("idle_valid_err", err_psum, exp_err);
        fill_random(2, 5);
        run_job(5, 2, 16'h0300, 1, 1);

        // Empty jobs
        run_job(0, 1, 16'h0400, 0, 0);
        run_job(3, 0, 16'h0400, 0, 0);

        // Reset after the first of three passes
        fill_random(3, 2);
        step();
        i_start = 1'b1;
        i_num_pixel = PW'(2);
        i_num_pass = PSW'(3);
        i_base_addr = 16'h0500;
        step();
        i_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            i_psum = job_data[0][p];
            i_psum_val = '1;
            step();
        end
        i_psum_val = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_err = '0;
        done_cnt = 0;
        @(negedge clk);
        check("midrst_ctrl", {o_wr_val, o_busy, o_done}, 0);
        check("midrst_err", err_psum, 0);
        check("midrst_data", o_wr_data, 0);
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        fill_random(3, 2);
        run_job(2, 3, 16'h0500, 0, 0);

        // Randomized jobs with a jittery ready
        ready_mode = 1;
        for (int j = 0; j < 8; j++) begin
            int np, npass;
            np = $urandom_range(1, 24);
            npass = $urandom_range(1, 3);
            fill_random(npass, np);
            run_job(np, npass, AW'($urandom), 1, (j == 3));
        end

        // Oversized pixel count clamps to the buffer depth
        fill_random(1, MAXP);
        run_job(300, 1, AW'($urandom), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
